// File: rtl/touch_scan_sequencer_if.sv
// Handshake between the touch scan sequencer (master) and the dual-channel serial ADC controller (slave).
interface touch_scan_sequencer_if #(
    parameter int DATA_W = 12
);
    logic              adc_start;
    logic              adc_done;
    logic [DATA_W-1:0] adc_data1;
    logic [DATA_W-1:0] adc_data2;

    modport master (
        output adc_start,
        input  adc_done,
        input  adc_data1,
        input  adc_data2
    );

    modport slave (
        input  adc_start,
        output adc_done,
        output adc_data1,
        output adc_data2
    );
endinterface

// File: rtl/touch_scan_sequencer.sv
// Resistive touch panel frame scheduler: settle/convert X then Y, pen-down detect, publish coordinates.
// Define TOUCH_AVG_EN to average four conversions per axis; otherwise a single raw sample is used.
module touch_scan_sequencer #(
    parameter int          SETTLE_CYCLES  = 250000,
    parameter int          GAP_CYCLES     = 500000,
    parameter int          TIMEOUT_CYCLES = 4096,
    parameter logic [11:0] PEN_THRESH     = 12'd64
) (
    input  logic                          clk50,
    input  logic                          reset,
    input  logic                          enable,
    touch_scan_sequencer_if.master        adc,
    output logic                          drive_x,
    output logic                          drive_y,
    output logic [11:0]                   x_out,
    output logic [11:0]                   y_out,
    output logic                          sample_valid,
    output logic                          pen_down,
    output logic                          timeout,
    output logic                          busy
);

    localparam int DATA_W = 12;
`ifdef TOUCH_AVG_EN
    localparam int NCONV = 4;
    localparam int ACC_W = 14;
    localparam int SHIFT = 2;
`else
    localparam int NCONV = 1;
    localparam int ACC_W = 12;
    localparam int SHIFT = 0;
`endif

    // Counters run down to zero, so each load is one less than the interval length.
    // The wait load is two less so the registered timeout pulse lands TIMEOUT_CYCLES after adc_start.
    localparam int SETTLE_LOAD = (SETTLE_CYCLES > 1) ? SETTLE_CYCLES - 1 : 0;
    localparam int GAP_LOAD    = (GAP_CYCLES > 1) ? GAP_CYCLES - 1 : 0;
    localparam int TO_LOAD     = (TIMEOUT_CYCLES > 2) ? TIMEOUT_CYCLES - 2 : 0;
    localparam int MAX_SG      = (SETTLE_LOAD > GAP_LOAD) ? SETTLE_LOAD : GAP_LOAD;
    localparam int CNT_MAX     = (MAX_SG > TO_LOAD) ? MAX_SG : TO_LOAD;
    localparam int CNT_W       = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

    typedef enum logic [3:0] {
        IDLE,
        SETTLE_X,
        CONV_X,
        WAIT_X,
        SETTLE_Y,
        CONV_Y,
        WAIT_Y,
        REPORT,
        GAP
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic [1:0]         conv_cnt;
    logic               conv_last;
    logic               conv_clr;
    logic               conv_inc;
    logic               acc_clr;
    logic               add_x;
    logic               add_y;
    logic               to_pulse;
    logic               report;
    logic [ACC_W-1:0]   acc_x;
    logic [ACC_W-1:0]   acc_y;
    logic [DATA_W-1:0]  x_res;
    logic [DATA_W-1:0]  y_res;
    logic               pen_hit;

    function automatic logic [DATA_W-1:0] avg_result(input logic [ACC_W-1:0] acc);
        return DATA_W'(acc >> SHIFT);
    endfunction

    function automatic logic above_thresh(input logic [DATA_W-1:0] res);
        return (res >= PEN_THRESH);
    endfunction

    assign conv_last = (conv_cnt == 2'(NCONV - 1));
    assign x_res     = avg_result(acc_x);
    assign y_res     = avg_result(acc_y);
    assign pen_hit   = above_thresh(x_res) && above_thresh(y_res);

    always_comb begin
        next_state = state;
        cnt_next   = (cnt != '0) ? cnt - CNT_W'(1) : cnt;
        conv_clr   = 1'b0;
        conv_inc   = 1'b0;
        acc_clr    = 1'b0;
        add_x      = 1'b0;
        add_y      = 1'b0;
        to_pulse   = 1'b0;
        report     = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    next_state = SETTLE_X;
                    cnt_next   = CNT_W'(SETTLE_LOAD);
                    acc_clr    = 1'b1;
                    conv_clr   = 1'b1;
                end
            end
            SETTLE_X: begin
                if (!enable)         next_state = IDLE;
                else if (cnt == '0)  next_state = CONV_X;
            end
            CONV_X: begin
                if (!enable) begin
                    next_state = IDLE;
                end else begin
                    next_state = WAIT_X;
                    cnt_next   = CNT_W'(TO_LOAD);
                end
            end
            WAIT_X: begin
                // A done arriving in the last waiting cycle still wins over the timeout.
                if (adc.adc_done) begin
                    add_x    = 1'b1;
                    conv_inc = 1'b1;
                    if (!enable) begin
                        next_state = IDLE;
                    end else if (!conv_last) begin
                        next_state = CONV_X;
                    end else begin
                        next_state = SETTLE_Y;
                        cnt_next   = CNT_W'(SETTLE_LOAD);
                        conv_clr   = 1'b1;
                    end
                end else if (cnt == '0) begin
                    to_pulse   = 1'b1;
                    next_state = enable ? GAP : IDLE;
                    cnt_next   = CNT_W'(GAP_LOAD);
                end
            end
            SETTLE_Y: begin
                if (!enable)         next_state = IDLE;
                else if (cnt == '0)  next_state = CONV_Y;
            end
            CONV_Y: begin
                if (!enable) begin
                    next_state = IDLE;
                end else begin
                    next_state = WAIT_Y;
                    cnt_next   = CNT_W'(TO_LOAD);
                end
            end
            WAIT_Y: begin
                if (adc.adc_done) begin
                    add_y    = 1'b1;
                    conv_inc = 1'b1;
                    if (!enable) begin
                        next_state = IDLE;
                    end else if (!conv_last) begin
                        next_state = CONV_Y;
                    end else begin
                        next_state = REPORT;
                    end
                end else if (cnt == '0) begin
                    to_pulse   = 1'b1;
                    next_state = enable ? GAP : IDLE;
                    cnt_next   = CNT_W'(GAP_LOAD);
                end
            end
            REPORT: begin
                report     = 1'b1;
                next_state = GAP;
                cnt_next   = CNT_W'(GAP_LOAD);
            end
            GAP: begin
                if (!enable) begin
                    next_state = IDLE;
                end else if (cnt == '0) begin
                    next_state = SETTLE_X;
                    cnt_next   = CNT_W'(SETTLE_LOAD);
                    acc_clr    = 1'b1;
                    conv_clr   = 1'b1;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Control and output registers; outputs are decoded from next_state so they line up with the state.
    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            conv_cnt      <= '0;
            adc.adc_start <= 1'b0;
            drive_x       <= 1'b0;
            drive_y       <= 1'b0;
            busy          <= 1'b0;
            timeout       <= 1'b0;
            sample_valid  <= 1'b0;
            pen_down      <= 1'b0;
            x_out         <= '0;
            y_out         <= '0;
        end else begin
            state         <= next_state;
            cnt           <= cnt_next;
            if (conv_clr)      conv_cnt <= '0;
            else if (conv_inc) conv_cnt <= conv_cnt + 2'd1;
            adc.adc_start <= (next_state == CONV_X) || (next_state == CONV_Y);
            drive_x       <= (next_state == SETTLE_X) || (next_state == CONV_X) || (next_state == WAIT_X);
            drive_y       <= (next_state == SETTLE_Y) || (next_state == CONV_Y) || (next_state == WAIT_Y);
            busy          <= (next_state != IDLE);
            timeout       <= to_pulse;
            sample_valid  <= report && pen_hit;
            if (report) begin
                pen_down <= pen_hit;
                if (pen_hit) begin
                    x_out <= x_res;
                    y_out <= y_res;
                end
            end
        end
    end

    // Accumulator datapath: cleared at the start of every frame, so no reset is needed.
    always_ff @(posedge clk50) begin
        if (acc_clr) begin
            acc_x <= '0;
            acc_y <= '0;
        end else begin
            if (add_x) acc_x <= acc_x + ACC_W'(adc.adc_data1);
            if (add_y) acc_y <= acc_y + ACC_W'(adc.adc_data2);
        end
    end

endmodule

// File: doc/touch_scan_sequencer.md
# touch_scan_sequencer

Frame scheduler for the resistive touch panel. It alternately drives the X and Y planes and waits a settling interval on each. It then issues conversion requests to the dual-channel serial ADC controller, optionally averages four results per axis, applies pen-down detection and publishes a coordinate pair with a one-cycle valid. It sits between the ADC controller (start/done/data handshake) and the panel tri-state drivers, and feeds the display/LED path.

## Interface
- SETTLE_CYCLES, 250000, plane settling time in clock cycles (5 ms at 50 MHz), minimum 1
- GAP_CYCLES, 500000, idle cycles between frames, minimum 1
- TIMEOUT_CYCLES, 4096, maximum cycles to wait for adc_done after adc_start
- PEN_THRESH, 12'd64, minimum per-axis result counted as a touch
- clk50  input  1  system clock; all logic on rising edge
- reset  input  1  asynchronous, active-high
- enable  input  1  level; run frames while high
- adc_start  output  1  one-cycle conversion request to the ADC controller
- adc_done  input  1  one-cycle completion pulse, synchronous to clk50
- adc_data1  input  12  ADC channel 1 result, used for X; valid while adc_done is high
- adc_data2  input  12  ADC channel 2 result, used for Y; valid while adc_done is high
- drive_x  output  1  enables X-plane drive (x1=0, x2=1)
- drive_y  output  1  enables Y-plane drive (y1=0, y2=1)
- x_out  output  12  last valid X coordinate
- y_out  output  12  last valid Y coordinate
- sample_valid  output  1  one-cycle pulse when x_out and y_out update
- pen_down  output  1  result of the most recent completed frame
- timeout  output  1  one-cycle pulse when a conversion is abandoned
- busy  output  1  high in every state except IDLE

## Operation
- States: IDLE, SETTLE_X, CONV_X, WAIT_X, SETTLE_Y, CONV_Y, WAIT_Y, REPORT, GAP.
- IDLE: go to SETTLE_X when enable=1.
- SETTLE_x: counter loaded on entry. State lasts exactly SETTLE_CYCLES cycles, then goes to CONV_x.
- CONV_x: adc_start=1 for this single cycle. Next state is WAIT_x. The timeout counter loads TIMEOUT_CYCLES.
- WAIT_x: on adc_done, add the channel data (data1 for X, data2 for Y) into a 14-bit accumulator.
  - If more conversions remain for the axis, go to CONV_x. There is no re-settle.
  - Otherwise X goes to SETTLE_Y and Y goes to REPORT.
- adc_done outside WAIT states is ignored.
- Timeout: if the counter reaches 0 in WAIT_x without adc_done, pulse timeout, discard the frame and go to GAP. pen_down and the outputs are unchanged.
- REPORT: result = accumulator >> log2(conversions), truncated.
  - pen_down <= (Xres >= PEN_THRESH) & (Yres >= PEN_THRESH).
  - If pen down: x_out/y_out load the results and sample_valid pulses. Otherwise x_out/y_out hold.
  - Next state is GAP.
- GAP: lasts GAP_CYCLES cycles. Then goes to SETTLE_X if enable=1, else IDLE.
- drive_x is high exactly in SETTLE_X, CONV_X and WAIT_X. drive_y is high exactly in SETTLE_Y, CONV_Y and WAIT_Y. They are never both high.
- enable=0:
  - In SETTLE, CONV or GAP: go to IDLE next cycle.
  - In WAIT: finish the conversion (done or timeout) first, then go to IDLE with no REPORT.
  - A partial frame is never reported.
- Accumulators and conversion count clear on entry to SETTLE_X.

## Timing
- Reset (asynchronous) forces IDLE and clears every output to 0: adc_start, drive_x, drive_y, x_out, y_out, sample_valid, pen_down, timeout, busy.
- All outputs are registered. No combinational path from input to output.
- Minimum frame, one conversion per axis, ADC latency L cycles from start to done: 2×(SETTLE_CYCLES + 1 + L) + 1 cycles from leaving IDLE to the sample_valid cycle.
- sample_valid is coincident with the updated x_out/y_out. The values hold until the next pen-down REPORT.
- adc_done coincident with the timeout-zero cycle counts as done, not as a timeout.

## Configuration
- TOUCH_AVG_EN defined: four conversions per axis, result = sum >> 2.
- TOUCH_AVG_EN undefined: one conversion per axis, result = the raw 12-bit sample, accumulator width 12.

## Test plan
Use SETTLE_CYCLES=4, GAP_CYCLES=8, TIMEOUT_CYCLES=16, PEN_THRESH=64, and an ADC model returning done 3 cycles after start.
- Reset asserted mid-SETTLE_X -> drive_x=0 and busy=0 immediately, all outputs 0, state IDLE.
- No AVG, enable=1, data1=0x800, data2=0x400 -> one sample_valid with x_out=0x800, y_out=0x400, pen_down=1; drive_x high 8 cycles, then drive_y high 8 cycles, never overlapping.
- TOUCH_AVG_EN, X samples 100,101,102,103 and Y samples 200×4 -> x_out=101, y_out=200, exactly four adc_start pulses per axis.
- Frame with data1=data2=10 after a valid frame -> pen_down=0, no sample_valid, x_out/y_out hold the prior values.
- ADC model never answers in WAIT_Y -> timeout pulses 16 cycles after adc_start, drive_y=0, no sample_valid, next frame starts after 8 GAP cycles.
- enable dropped in WAIT_X -> done accepted, state IDLE, busy=0, no SETTLE_Y and no sample_valid.
